// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU issue sequencer.
//   alu_op_t    - the ten op codes the downstream ALU implements
//   cmd_t       - one latched command {op, rd, rs1, rs2}
//   seq_state_t - sequencer FSM states
//   REG_AW      - register index width
//   DATA_W      - data width shared with the ALU
package alu_pkg;

  localparam int REG_AW = 3;
  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_t;

  // op is kept as raw bits: illegal codes are forwarded untouched and the
  // ALU reports them through its hata flag.
  typedef struct packed {
    logic [3:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE_OP = 2'd1,
    S_ISSUE_AB = 2'd2,
    S_WB       = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_issue_seq_if.sv
// alu_issue_seq_if: bundle of the sequencer's command, load and ALU buses.
//   cmd_*  - command channel (valid/ready) into the sequencer
//   ld_*   - external register-load channel (valid/ready)
//   alu_*  - op/operand outputs to the ALU and its registered result/flags
// Modports:
//   slave  - sequencer side
//   master - environment side (command source, loader and the ALU itself)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The source holds its payload stable while valid is high
// and ready is low; ready may be high without valid and carries no meaning
// by itself. Both channels follow this rule.
interface alu_issue_seq_if
  import alu_pkg::*;
#(
  parameter int W = DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rs1;
  logic [REG_AW-1:0] cmd_rs2;

  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_addr;
  logic [W-1:0]      ld_data;

  logic [3:0]        alu_op;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [W-1:0]      alu_s;
  logic              alu_n;
  logic              alu_z;
  logic              alu_v;
  logic              alu_c;
  logic              alu_hata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
    output cmd_ready,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    output alu_op, alu_a, alu_b,
    input  alu_s, alu_n, alu_z, alu_v, alu_c, alu_hata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
    input  cmd_ready,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    input  alu_op, alu_a, alu_b,
    output alu_s, alu_n, alu_z, alu_v, alu_c, alu_hata
  );

endinterface

// File: rtl/regfile_8x32.sv
// regfile_8x32: register file behind the issue sequencer.
//   i_clk, i_rst_n         - clock, async active-low clear of every entry
//   i_rs1_addr/o_rs1_data  - combinational operand read port A
//   i_rs2_addr/o_rs2_data  - combinational operand read port B
//   i_dbg_addr/o_dbg_data  - combinational debug read port
//   i_wb_en/addr/data      - writeback write request (wins over load)
//   i_ld_en/addr/data      - external load write request
// Entry 0 reads as zero and silently drops writes.
module regfile_8x32
  import alu_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int NREGS = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_rs1_addr,
  output logic [W-1:0]      o_rs1_data,
  input  logic [REG_AW-1:0] i_rs2_addr,
  output logic [W-1:0]      o_rs2_data,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [W-1:0]      o_dbg_data,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [W-1:0]      i_wb_data,
  input  logic              i_ld_en,
  input  logic [REG_AW-1:0] i_ld_addr,
  input  logic [W-1:0]      i_ld_data
);

  logic [W-1:0]      r_mem [NREGS];
  logic              w_we;
  logic [REG_AW-1:0] w_waddr;
  logic [W-1:0]      w_wdata;

  // Single write port. The sequencer already blocks loads during
  // writeback, so the priority only matters if that ever changes.
  assign w_we    = i_wb_en | i_ld_en;
  assign w_waddr = i_wb_en ? i_wb_addr : i_ld_addr;
  assign w_wdata = i_wb_en ? i_wb_data : i_ld_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we && (w_waddr != '0)) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign o_rs1_data = (i_rs1_addr == '0) ? '0 : r_mem[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == '0) ? '0 : r_mem[i_rs2_addr];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issue sequencer in front of a registered 32-bit ALU.
//   clk, rst_n  - clock, async active-low reset
//   bus         - command / load / ALU buses (alu_issue_seq_if.slave)
//   stat_nzvc   - {n,z,v,c} of the last command that retired without hata
//   err         - sticky illegal-op flag, cleared only by reset
//   done        - one-cycle pulse in the writeback cycle
//   dbg_addr    - debug register read address
//   dbg_data    - combinational contents of that register
//   dbg_state   - current FSM state
// One command every four cycles: IDLE -> ISSUE_OP -> ISSUE_AB -> WB.
// The ALU latches its op one edge before its operands, so the op is put on
// alu_op in ISSUE_OP and held through ISSUE_AB while the operands appear.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int NREGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_seq_if.slave    bus,
  output logic [3:0]        stat_nzvc,
  output logic              err,
  output logic              done,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [W-1:0]      dbg_data,
  output seq_state_t        dbg_state
);

  seq_state_t   r_state;
  seq_state_t   w_state_next;
  cmd_t         r_cmd;
  logic [3:0]   r_stat;
  logic         r_err;

  logic         w_latch;
  logic         w_cmd_ready;
  logic         w_ld_ready;
  logic         w_ld_en;
  logic         w_wb_en;
  logic         w_set_err;
  logic         w_done;
  logic [3:0]   w_alu_op;
  logic [W-1:0] w_alu_a;
  logic [W-1:0] w_alu_b;
  logic [W-1:0] w_rs1_data;
  logic [W-1:0] w_rs2_data;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and all per-state outputs
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_cmd_ready  = 1'b0;
    w_ld_ready   = 1'b1;
    w_wb_en      = 1'b0;
    w_set_err    = 1'b0;
    w_done       = 1'b0;
    w_alu_op     = '0;
    w_alu_a      = '0;
    w_alu_b      = '0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_latch      = 1'b1;
          w_state_next = S_ISSUE_OP;
        end
      end
      S_ISSUE_OP: begin
        w_alu_op     = r_cmd.op;
        w_state_next = S_ISSUE_AB;
      end
      S_ISSUE_AB: begin
        // Read now, not at acceptance, so a load that landed in the
        // meantime is what the ALU sees.
        w_alu_op     = r_cmd.op;
        w_alu_a      = w_rs1_data;
        w_alu_b      = w_rs2_data;
        w_state_next = S_WB;
      end
      S_WB: begin
        // The write port belongs to writeback this cycle.
        w_ld_ready   = 1'b0;
        w_done       = 1'b1;
        w_wb_en      = ~bus.alu_hata;
        w_set_err    = bus.alu_hata;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Command latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= '0;
    end else if (w_latch) begin
      r_cmd.op  <= bus.cmd_op;
      r_cmd.rd  <= bus.cmd_rd;
      r_cmd.rs1 <= bus.cmd_rs1;
      r_cmd.rs2 <= bus.cmd_rs2;
    end
  end

  // Status word follows only successful commands; err is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_wb_en) begin
        r_stat <= {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c};
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_ld_en = bus.ld_valid & w_ld_ready;

  regfile_8x32 #(
    .W     (W),
    .NREGS (NREGS)
  ) u_rf (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rs1_addr (r_cmd.rs1),
    .o_rs1_data (w_rs1_data),
    .i_rs2_addr (r_cmd.rs2),
    .o_rs2_data (w_rs2_data),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data),
    .i_wb_en    (w_wb_en),
    .i_wb_addr  (r_cmd.rd),
    .i_wb_data  (bus.alu_s),
    .i_ld_en    (w_ld_en),
    .i_ld_addr  (bus.ld_addr),
    .i_ld_data  (bus.ld_data)
  );

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.ld_ready  = w_ld_ready;
  assign bus.alu_op    = w_alu_op;
  assign bus.alu_a     = w_alu_a;
  assign bus.alu_b     = w_alu_b;
  assign stat_nzvc     = r_stat;
  assign err           = r_err;
  assign done          = w_done;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed bench for alu_issue_seq with a behavioural
// registered ALU attached to the ALU side of the bus.
module tb_alu_issue_seq;
  import alu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_seq_if #(.W(W)) bus();

  logic [3:0]        stat_nzvc;
  logic              err;
  logic              done;
  logic [REG_AW-1:0] dbg_addr;
  logic [W-1:0]      dbg_data;
  seq_state_t        dbg_state;

  alu_issue_seq #(.W(W), .NREGS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stat_nzvc (stat_nzvc),
    .err       (err),
    .done      (done),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // ---------------- ALU model: op latched one edge before operands ------
  function automatic logic [36:0] alu_f(input logic [3:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W:0]   t;
    logic [W-1:0] s;
    logic         v, c, h;
    v = 1'b0; c = 1'b0; h = 1'b0; s = '0; t = '0;
    case (op)
      4'b0000: begin
        t = {1'b0, a} + {1'b0, b}; s = t[W-1:0]; c = t[W];
        v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      4'b1000: begin
        s = a - b; c = (a >= b);
        v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end
      4'b0001: s = a << b[4:0];
      4'b0010: s = {31'd0, ($signed(a) < $signed(b))};
      4'b0011: s = {31'd0, (a < b)};
      4'b0100: s = a ^ b;
      4'b0101: s = a >> b[4:0];
      4'b1101: s = $signed(a) >>> b[4:0];
      4'b0110: s = a | b;
      4'b0111: s = a & b;
      default: h = 1'b1;
    endcase
    return {h, s[W-1], (s == '0), v, c, s};
  endfunction

  logic [3:0]  alu_op_q;
  logic [36:0] alu_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_q <= '0;
      alu_res  <= '0;
    end else begin
      alu_op_q <= bus.alu_op;
      alu_res  <= alu_f(alu_op_q, bus.alu_a, bus.alu_b);
    end
  end
  assign bus.alu_s    = alu_res[31:0];
  assign bus.alu_c    = alu_res[32];
  assign bus.alu_v    = alu_res[33];
  assign bus.alu_z    = alu_res[34];
  assign bus.alu_n    = alu_res[35];
  assign bus.alu_hata = alu_res[36];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rf_check(input string name, input logic [2:0] addr,
                          input logic [W-1:0] exp);
    dbg_addr = addr;
    #1;
    check(name, dbg_data, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [2:0] addr, input logic [W-1:0] data);
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    @(negedge clk);
    bus.ld_valid = 1'b0;
  endtask

  // Presents one command, leaves the bench at the ISSUE_OP negedge.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // From the ISSUE_OP negedge, waits (bounded) for done and checks latency.
  task automatic wait_done();
    int lat;
    lat = 1;
    while (done !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) check("done_timeout", 0, 1);
    else check("done_latency", lat, 3);
  endtask

  // Issue, wait for retire, step to the following IDLE negedge.
  task automatic run_cmd(input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2);
    issue(op, rd, rs1, rs2);
    wait_done();
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] v1;
    logic [W-1:0] v2;
    logic [3:0]   op;
    logic [2:0]   rd;
    logic [2:0]   rs1;
    logic [2:0]   rs2;
    logic [W-1:0] exp_rd;
    logic [3:0]   exp_nzvc;
  } vec_t;

  vec_t vecs[14];
  logic exp_err;

  initial begin
    vecs[0]  = '{32'h5,          32'h7,          4'b0000, 3'd3, 3'd1, 3'd2, 32'd12,         4'b0000};
    vecs[1]  = '{32'h8000_0000,  32'h1,          4'b1000, 3'd4, 3'd1, 3'd1, 32'h0,          4'b0101};
    vecs[2]  = '{32'h7FFF_FFFF,  32'h1,          4'b0000, 3'd5, 3'd1, 3'd2, 32'h8000_0000,  4'b1010};
    vecs[3]  = '{32'hFFFF_FFFF,  32'h1,          4'b0000, 3'd6, 3'd1, 3'd2, 32'h0,          4'b0101};
    vecs[4]  = '{32'h3,          32'h5,          4'b1000, 3'd7, 3'd1, 3'd2, 32'hFFFF_FFFE,  4'b1000};
    vecs[5]  = '{32'h1,          32'h4,          4'b0001, 3'd3, 3'd1, 3'd2, 32'h10,         4'b0000};
    vecs[6]  = '{32'hFFFF_FFFF,  32'h1,          4'b0010, 3'd4, 3'd1, 3'd2, 32'h1,          4'b0000};
    vecs[7]  = '{32'hFFFF_FFFF,  32'h1,          4'b0011, 3'd5, 3'd1, 3'd2, 32'h0,          4'b0100};
    vecs[8]  = '{32'hF0F0_F0F0,  32'hFFFF_0000,  4'b0100, 3'd6, 3'd1, 3'd2, 32'h0F0F_F0F0,  4'b0000};
    vecs[9]  = '{32'h8000_0000,  32'd31,         4'b0101, 3'd7, 3'd1, 3'd2, 32'h1,          4'b0000};
    vecs[10] = '{32'h8000_0000,  32'd4,          4'b1101, 3'd3, 3'd1, 3'd2, 32'hF800_0000,  4'b1000};
    vecs[11] = '{32'h00FF_0000,  32'h0000_00FF,  4'b0110, 3'd4, 3'd1, 3'd2, 32'h00FF_00FF,  4'b0000};
    vecs[12] = '{32'hF0F0_F0F0,  32'hFF00_FF00,  4'b0111, 3'd5, 3'd1, 3'd2, 32'hF000_F000,  4'b1000};
    vecs[13] = '{32'h5,          32'h7,          4'b0000, 3'd0, 3'd1, 3'd2, 32'h0,          4'b0000};

    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0;
    bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    dbg_addr = '0;
    exp_err = 1'b0;

    // ---- reset state ----
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_ld_ready",  bus.ld_ready, 1);
    check("rst_alu_op",    bus.alu_op, 0);
    check("rst_alu_a",     bus.alu_a, 0);
    check("rst_alu_b",     bus.alu_b, 0);
    check("rst_stat",      stat_nzvc, 0);
    check("rst_err",       err, 0);
    check("rst_done",      done, 0);
    check("rst_state",     dbg_state, S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 14; i++) begin
      do_load(vecs[i].rs1, vecs[i].v1);
      if (vecs[i].rs2 != vecs[i].rs1) do_load(vecs[i].rs2, vecs[i].v2);
      exp_q.push_back(vecs[i].exp_rd);
      run_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
      rf_check($sformatf("vec%0d_rd", i), vecs[i].rd, exp_q.pop_front());
      check($sformatf("vec%0d_nzvc", i), stat_nzvc, vecs[i].exp_nzvc);
      check($sformatf("vec%0d_err", i), err, exp_err);
    end

    // ---- op/operand skew: sub r3 = 9 - 4 ----
    do_load(3'd1, 32'd9);
    do_load(3'd2, 32'd4);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'b1000;
    bus.cmd_rd = 3'd3; bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("skew_op_state",  dbg_state, S_ISSUE_OP);
    check("skew_op_op",     bus.alu_op, 4'b1000);
    check("skew_op_a",      bus.alu_a, 0);
    check("skew_op_b",      bus.alu_b, 0);
    check("skew_op_ready",  bus.cmd_ready, 0);
    @(negedge clk);
    check("skew_ab_op",     bus.alu_op, 4'b1000);
    check("skew_ab_a",      bus.alu_a, 32'd9);
    check("skew_ab_b",      bus.alu_b, 32'd4);
    @(negedge clk);
    check("skew_wb_done",   done, 1);
    check("skew_wb_op",     bus.alu_op, 0);
    check("skew_wb_ldrdy",  bus.ld_ready, 0);
    @(negedge clk);
    rf_check("skew_r3", 3'd3, 32'd5);
    check("skew_nzvc", stat_nzvc, 4'b0001);

    // ---- illegal op: err set, rd and status untouched ----
    do_load(3'd5, 32'hAA);
    issue(4'b1001, 3'd5, 3'd1, 3'd2);
    wait_done();
    check("ill_err_not_yet", err, 0);
    @(negedge clk);
    exp_err = 1'b1;
    rf_check("ill_r5", 3'd5, 32'hAA);
    check("ill_nzvc", stat_nzvc, 4'b0001);
    check("ill_err", err, exp_err);

    // ---- back-to-back with cmd_valid held ----
    do_load(3'd4, 32'hFF);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'b0000;
    bus.cmd_rd = 3'd3; bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2;
    @(negedge clk);
    bus.cmd_op = 4'b0111; bus.cmd_rd = 3'd4;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("b2b_ready_%0d", k), bus.cmd_ready, (k == 4) ? 1 : 0);
      if (k < 4) @(negedge clk);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("b2b_accepted", bus.cmd_ready, 0);
    wait_done();
    @(negedge clk);
    rf_check("b2b_r3", 3'd3, 32'd13);
    rf_check("b2b_r4", 3'd4, 32'd0);
    check("b2b_nzvc", stat_nzvc, 4'b0100);

    // ---- held load to the destination register ----
    do_load(3'd2, 32'd20);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'b0000;
    bus.cmd_rd = 3'd6; bus.cmd_rs1 = 3'd6; bus.cmd_rs2 = 3'd2;
    bus.ld_valid = 1'b1; bus.ld_addr = 3'd6; bus.ld_data = 32'h1234;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("ldh_ready_op", bus.ld_ready, 1);
    @(negedge clk);
    check("ldh_ab_a", bus.alu_a, 32'h1234);
    @(negedge clk);
    check("ldh_ready_wb", bus.ld_ready, 0);
    check("ldh_done", done, 1);
    @(negedge clk);
    rf_check("ldh_r6_wb", 3'd6, 32'h1248);
    check("ldh_ready_idle", bus.ld_ready, 1);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    rf_check("ldh_r6_final", 3'd6, 32'h1234);
    check("ldh_nzvc", stat_nzvc, 4'b0000);

    // ---- reset during ISSUE_AB ----
    do_load(3'd1, 32'd3);
    do_load(3'd2, 32'd4);
    issue(4'b0000, 3'd3, 3'd1, 3'd2);
    @(negedge clk);
    check("mid_state_ab", dbg_state, S_ISSUE_AB);
    rst_n = 1'b0;
    #1;
    check("mid_state",     dbg_state, S_IDLE);
    check("mid_cmd_ready", bus.cmd_ready, 1);
    check("mid_ld_ready",  bus.ld_ready, 1);
    check("mid_alu_op",    bus.alu_op, 0);
    check("mid_alu_a",     bus.alu_a, 0);
    check("mid_alu_b",     bus.alu_b, 0);
    check("mid_stat",      stat_nzvc, 0);
    check("mid_err",       err, 0);
    check("mid_done",      done, 0);
    rf_check("mid_r1", 3'd1, 32'd0);
    rf_check("mid_r3", 3'd3, 32'd0);
    exp_err = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_no_done", done, 0);
    end
    rst_n = 1'b1;
    do_load(3'd1, 32'd5);
    do_load(3'd2, 32'd7);
    run_cmd(4'b0000, 3'd3, 3'd1, 3'd2);
    rf_check("post_r3", 3'd3, 32'd12);
    check("post_nzvc", stat_nzvc, 4'b0000);
    check("post_err", err, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
